rect_fill_writer: RTL

//  Write-side engine for the 160x120 8-bit (RGB332) framebuffer. Accepts one

---
 rtl/rect_fill_writer_if.sv | 36 +++
 rtl/rect_fill_writer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rect_fill_writer_if.sv
// rect_fill_writer_if: command handshake plus framebuffer write port.
// master drives cmd_* and fb_ready; slave is the fill engine.
interface rect_fill_writer_if #(
  parameter int COORD_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [COORD_W-1:0] cmd_w;
  logic [COORD_W-1:0] cmd_h;
  logic [7:0]         cmd_color;
  logic               fb_ready;
  logic               write;
  logic [COORD_W-1:0] x_data;
  logic [COORD_W-1:0] y_data;
  logic [7:0]         color;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_x, cmd_y,
    output cmd_w, cmd_h, cmd_color,
    output fb_ready,
    input  cmd_ready, write, x_data,
    input  y_data, color, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y,
    input  cmd_w, cmd_h, cmd_color,
    input  fb_ready,
    output cmd_ready, write, x_data,
    output y_data, color, busy, done
  );
endinterface

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: fills a rectangle in the 160x120 RGB332 framebuffer,
// one pixel write per accepted cycle, row-major.
// Ports: clk, rst (async, active-high), bus (slave): cmd_valid/ready,
// cmd_x/y/w/h/color in; fb_ready in; write, x_data, y_data, color,
// busy, done out. Define CLIP_EN to clip to SCREEN_W x SCREEN_H.
module rect_fill_writer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COORD_W  = 8
) (
  input  logic clk,
  input  logic rst,
  rect_fill_writer_if.slave bus
);
  localparam logic [COORD_W-1:0] ONE =
    {{(COORD_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] w_eff, h_eff;
  logic [COORD_W-1:0] x_q, y_q;
  logic [7:0]         c_q;
  logic [COORD_W-1:0] x0_q, wm1_q;
  logic [COORD_W-1:0] col_q, row_q;
  logic               done_q;
  logic               accept, empty;
  logic               step, last;

`ifdef CLIP_EN
  localparam int CW = COORD_W + 1;
  localparam logic [CW-1:0] SW = CW'(SCREEN_W);
  localparam logic [CW-1:0] SH = CW'(SCREEN_H);

  logic [CW-1:0] x_ext, y_ext;
  logic [CW-1:0] w_ext, h_ext;
  logic [CW-1:0] w_room, h_room;

  // One extra bit so SCREEN - origin cannot wrap.
  always_comb begin
    x_ext  = {1'b0, bus.cmd_x};
    y_ext  = {1'b0, bus.cmd_y};
    w_ext  = {1'b0, bus.cmd_w};
    h_ext  = {1'b0, bus.cmd_h};
    w_room = SW - x_ext;
    h_room = SH - y_ext;
    w_eff  = bus.cmd_w;
    h_eff  = bus.cmd_h;
    if (x_ext >= SW || y_ext >= SH) begin
      w_eff = '0;
      h_eff = '0;
    end else begin
      if (w_ext > w_room)
        w_eff = w_room[COORD_W-1:0];
      if (h_ext > h_room)
        h_eff = h_room[COORD_W-1:0];
    end
  end
`else
  assign w_eff = bus.cmd_w;
  assign h_eff = bus.cmd_h;
`endif

  assign accept = bus.cmd_valid && (state == IDLE);
  assign empty  = (w_eff == '0) || (h_eff == '0);
  assign step   = (state == FILL) && bus.fb_ready;
  assign last   = step && (col_q == '0)
                       && (row_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && !empty) state_nxt = FILL;
      FILL: if (last)             state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // col_q/row_q count pixels left in the row and rows left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      x0_q   <= '0;
      wm1_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (accept && empty) || last;
      if (accept && !empty) begin
        x_q   <= bus.cmd_x;
        y_q   <= bus.cmd_y;
        c_q   <= bus.cmd_color;
        x0_q  <= bus.cmd_x;
        wm1_q <= w_eff - ONE;
        col_q <= w_eff - ONE;
        row_q <= h_eff - ONE;
      end else if (step) begin
        if (col_q != '0) begin
          x_q   <= x_q + ONE;
          col_q <= col_q - ONE;
        end else if (row_q != '0) begin
          x_q   <= x0_q;
          y_q   <= y_q + ONE;
          col_q <= wm1_q;
          row_q <= row_q - ONE;
        end
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.write     = (state == FILL);
  assign bus.busy      = (state == FILL);
  assign bus.done      = done_q;
  assign bus.x_data    = x_q;
  assign bus.y_data    = y_q;
  assign bus.color     = c_q;
endmodule
